pipe_stage_elastic: RTL and testbench

//   Parametrised elastic pipeline register for the RISC-V core; successor to fixed-width
//   wr_en-gated IF/ID, ID/EX, EX/MEM, MEM/WB regs. Valid/ready handshake per stage,
//   2-entry skid buffer, registered backpressure, synchronous flush.

---
 rtl/pipe_stage_elastic.sv | 112 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with 2-entry skid buffer (optional PIPE_PERF_CNT_EN counters)
module pipe_stage_elastic #(
    parameter int WIDTH  = 32,
    parameter     BUBBLE = 32'h0000_0013,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
`endif
    output logic [1:0]       occupancy
);

    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push, pop;

    // Ready depends only on the state register so backpressure never forms a combinational path
    assign in_ready  = rst && (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE_W;
    assign occupancy = state_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state and storage update; flush empties the stage and drops the incoming beat
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d = S_HALF;
                        main_d  = in_data;
                    end
                end
                S_HALF: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = S_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_d = S_HALF;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers carry no reset; their contents only matter while the state marks them valid
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating stall/bubble counters, classified on pre-flush handshake, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .WIDTH (WIDTH),
        .BUBBLE(32'h0000_0013),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;

        // reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_occ", 32'(occupancy), 32'd0);
            check("rst_out_data", out_data, 32'h13);
            check("rst_in_ready", 32'(in_ready), 32'd0);
        end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);

        // back-to-back stream, one cycle latency, no gaps
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", out_data, 32'(i));
            check("stream_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_occ", 32'(occupancy), 32'd0);
        check("stream_drain_valid", 32'(out_valid), 32'd0);

        // backpressure fills the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        check("bp_occ1", 32'(occupancy), 32'd1);
        check("bp_data_a", out_data, 32'hA);
        in_data = 32'hB;
        tick();
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_a", out_data, 32'hA);
        in_valid = 1'b0;
        tick();
        check("bp_still_a", out_data, 32'hA);
        check("bp_still_occ2", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        #1;
        check("bp_pop_a", out_data, 32'hA);
        tick();
        check("bp_pop_b", out_data, 32'hB);
        check("bp_occ_after1", 32'(occupancy), 32'd1);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("bp_occ_after2", 32'(occupancy), 32'd0);

        // simultaneous push and pop while HALF
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        tick();
        check("pp_main5", out_data, 32'h5);
        out_ready = 1'b1; in_data = 32'h6;
        tick();
        check("pp_occ", 32'(occupancy), 32'd1);
        check("pp_data6", out_data, 32'h6);
        in_valid = 1'b0;
        tick();
        check("pp_empty", 32'(occupancy), 32'd0);

        // flush from FULL drops held entries and same-cycle input
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        check("fl_full", 32'(occupancy), 32'd2);
        in_data = 32'h9; flush = 1'b1;
        tick();
        check("fl_occ", 32'(occupancy), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_data", out_data, 32'h13);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_9", 32'(out_valid), 32'd0);
        end

`ifdef PIPE_PERF_CNT_EN
        // saturating stall counter, unaffected by flush
        rst = 1'b0;
        tick();
        check("pc_rst_stall", 32'(stall_cnt), 32'd0);
        check("pc_rst_bubble", 32'(bubble_cnt), 32'd0);
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3;
        tick();
        check("pc_bubble1", 32'(bubble_cnt), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("pc_stall_sat", 32'(stall_cnt), 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pc_stall_flush", 32'(stall_cnt), 32'd15);
        check("pc_bubble_flush", 32'(bubble_cnt), 32'd1);
        tick();
        check("pc_bubble2", 32'(bubble_cnt), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
